// File: rtl/qerv_dbus_lsu.sv
// qerv_dbus_lsu: data-bus load/store unit behind the W-bit-serial buffer register.
// It collects store data serially from rs2 and runs one Wishbone-style data-bus
// transaction. Load data is aligned, extended and returned W bits per cycle.
// Only one memory operation is in flight at a time.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               begins an operation (sampled only in IDLE), with
//                         i_we, i_funct3, i_adr, i_lsb
//   i_en, i_rs2           serial store-data collection, LSB-first
//   o_dbus_*, i_dbus_*    data-bus request/response
//   o_rd, o_rd_valid      serial load result, LSB-first
//   o_busy, o_done        operation in progress / one-cycle completion pulse
module qerv_dbus_lsu #(
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_adr,
    input  logic [1:0]  i_lsb,
    input  logic        i_en,
    input  logic [B:0]  i_rs2,
    output logic [31:0] o_dbus_adr,
    output logic [31:0] o_dbus_dat,
    output logic [3:0]  o_dbus_sel,
    output logic        o_dbus_we,
    output logic        o_dbus_cyc,
    input  logic [31:0] i_dbus_rdt,
    input  logic        i_dbus_ack,
    output logic [B:0]  o_rd,
    output logic        o_rd_valid,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [4:0] STEP = 5'(W);
    localparam logic [4:0] LAST = 5'(32 - W);

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  cnt_r;
    logic [31:0] data_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] adr_r;
    logic [1:0]  lsb_r;
    logic        done_r;
    logic        cyc_s;
    logic        wrap_s;

    // Replicate the low byte/half into every lane so the byte enables pick it up.
    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // Byte enables; half ignores lsb[0] and word ignores lsb (misalignment trapped upstream).
    function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   byte_sel = 4'b0001 << lsb;
            2'b01:   byte_sel = 4'b0011 << {lsb[1], 1'b0};
            default: byte_sel = 4'b1111;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [31:0] load_align(input logic [31:0] rdt, input logic [2:0] funct3,
                                               input logic [1:0] lsb);
        logic [31:0] sh;
        logic        fill;
        case (funct3[1:0])
            2'b00: begin
                sh         = rdt >> {lsb, 3'b000};
                fill       = ~funct3[2] & sh[7];
                load_align = {{24{fill}}, sh[7:0]};
            end
            2'b01: begin
                sh         = rdt >> {lsb[1], 4'b0000};
                fill       = ~funct3[2] & sh[15];
                load_align = {{16{fill}}, sh[15:0]};
            end
            default: begin
                sh         = rdt;
                fill       = 1'b0;
                load_align = sh;
            end
        endcase
    endfunction

    assign cyc_s  = (state_r == ST_REQ);
    // The counter sits on its last step when the next advance wraps to zero.
    assign wrap_s = (cnt_r == LAST);

    // Next-state decode for the IDLE/FILL/REQ/DRAIN sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = i_we ? ST_FILL : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (i_en && wrap_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_REQ: begin
                if (i_dbus_ack) begin
                    state_s = we_r ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (wrap_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operation capture, serial data register and completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            data_r   <= 32'd0;
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            adr_r    <= 32'd0;
            lsb_r    <= 2'd0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        we_r     <= i_we;
                        funct3_r <= i_funct3;
                        adr_r    <= i_adr;
                        lsb_r    <= i_lsb;
                        cnt_r    <= 5'd0;
                    end
                end
                ST_FILL: begin
                    if (i_en) begin
                        data_r <= {i_rs2, data_r[31:W]};
                        cnt_r  <= cnt_r + STEP;
                    end
                end
                ST_REQ: begin
                    if (i_dbus_ack) begin
                        if (we_r) begin
                            done_r <= 1'b1;
                        end else begin
                            data_r <= load_align(i_dbus_rdt, funct3_r, lsb_r);
                        end
                    end
                end
                ST_DRAIN: begin
                    data_r <= data_r >> W;
                    cnt_r  <= cnt_r + STEP;
                    if (wrap_s) begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbus_cyc = cyc_s;
    assign o_dbus_adr = adr_r;
    assign o_dbus_dat = store_lanes(data_r, funct3_r[1:0]);
    assign o_dbus_sel = cyc_s ? byte_sel(funct3_r[1:0], lsb_r) : 4'b0000;
    assign o_dbus_we  = we_r & cyc_s;
    assign o_rd_valid = (state_r == ST_DRAIN);
    assign o_rd       = o_rd_valid ? data_r[B:0] : {W{1'b0}};
    assign o_busy     = (state_r != ST_IDLE);
    assign o_done     = done_r;

endmodule

// File: tb/tb_qerv_dbus_lsu.sv
// Self-checking bench for qerv_dbus_lsu: one W=1 instance (unit 0) and one W=4
// instance (unit 1), exercised one at a time against a word-level model.
module tb_qerv_dbus_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst[2];
    logic        s_start[2];
    logic        s_we[2];
    logic [2:0]  s_f3[2];
    logic [31:0] s_adr[2];
    logic [1:0]  s_lsb[2];
    logic        s_en[2];
    logic [3:0]  s_rs2[2];
    logic [31:0] s_rdt[2];
    logic        s_ack[2];

    logic [31:0] d_adr[2];
    logic [31:0] d_dat[2];
    logic [3:0]  d_sel[2];
    logic        d_we[2];
    logic        cyc[2];
    logic        rvalid[2];
    logic        busy[2];
    logic        done[2];
    logic [0:0]  rd0;
    logic [3:0]  rd1;
    logic [3:0]  rd[2];

    assign rd[0] = {3'b000, rd0};
    assign rd[1] = rd1;

    qerv_dbus_lsu #(.W(1)) u_w1 (
        .i_clk(clk), .i_rst(s_rst[0]), .i_start(s_start[0]), .i_we(s_we[0]),
        .i_funct3(s_f3[0]), .i_adr(s_adr[0]), .i_lsb(s_lsb[0]), .i_en(s_en[0]),
        .i_rs2(s_rs2[0][0:0]), .o_dbus_adr(d_adr[0]), .o_dbus_dat(d_dat[0]),
        .o_dbus_sel(d_sel[0]), .o_dbus_we(d_we[0]), .o_dbus_cyc(cyc[0]),
        .i_dbus_rdt(s_rdt[0]), .i_dbus_ack(s_ack[0]), .o_rd(rd0),
        .o_rd_valid(rvalid[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    qerv_dbus_lsu #(.W(4)) u_w4 (
        .i_clk(clk), .i_rst(s_rst[1]), .i_start(s_start[1]), .i_we(s_we[1]),
        .i_funct3(s_f3[1]), .i_adr(s_adr[1]), .i_lsb(s_lsb[1]), .i_en(s_en[1]),
        .i_rs2(s_rs2[1]), .o_dbus_adr(d_adr[1]), .o_dbus_dat(d_dat[1]),
        .o_dbus_sel(d_sel[1]), .o_dbus_we(d_we[1]), .o_dbus_cyc(cyc[1]),
        .i_dbus_rdt(s_rdt[1]), .i_dbus_ack(s_ack[1]), .o_rd(rd1),
        .o_rd_valid(rvalid[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    function automatic logic [31:0] m_load(input logic [31:0] r, input logic [2:0] f, input int l);
        logic [31:0] v;
        if (f[1:0] == 2'b00) begin
            v = (r >> (8 * l)) & 32'h0000_00FF;
            if (!f[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f[1:0] == 2'b01) begin
            v = (r >> (16 * (l / 2))) & 32'h0000_FFFF;
            if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] size);
        if (size == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [3:0] m_selv(input logic [1:0] size, input int l);
        if (size == 2'b00) return 4'(1 << l);
        if (size == 2'b01) return 4'(3 << (l & 2));
        return 4'hF;
    endfunction

    int          m_u = -1;
    logic        m_we = 1'b0;
    logic [31:0] m_adr, m_dat, m_res, m_wdat;
    logic [3:0]  m_sel;
    int          m_idx = 0;

    logic        n_we;
    logic [2:0]  n_f3;
    logic [31:0] n_adr, n_wdat, n_rdt;
    int          n_lsb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the expected outcome and raise i_start for unit u.
    task automatic op_set(input int u, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input int l, input logic [31:0] wdat, input logic [31:0] r);
        m_u = u; m_we = we; m_adr = a; m_wdat = wdat; m_idx = 0;
        m_sel = m_selv(f3[1:0], l);
        m_dat = m_store(wdat, f3[1:0]);
        m_res = m_load(r, f3, l);
        s_start[u] = 1'b1; s_we[u] = we; s_f3[u] = f3; s_adr[u] = a;
        s_lsb[u] = 2'(l); s_rdt[u] = r;
    endtask

    // Carry the started operation to completion, checking phase timing.
    task automatic op_run(input int ncyc, input int en_mode, input bit poke, input bit chain);
        int u;
        int n;
        int wid;
        u   = m_u;
        n   = (u == 1) ? 8 : 32;
        wid = (u == 1) ? 4 : 1;
        tick();
        s_start[u] = 1'b0;
        if (m_we) begin
            for (int k = 0; k < n; k++) begin
                if (en_mode == 1 || (en_mode == 2 && $urandom_range(0, 1) == 1)) begin
                    s_en[u] = 1'b0;
                    @(negedge clk);
                    chk("fill_hold_cyc", 32'(cyc[u]), 32'd0);
                    chk("fill_hold_busy", 32'(busy[u]), 32'd1);
                    tick();
                end
                s_en[u]  = 1'b1;
                s_rs2[u] = 4'((m_wdat >> (k * wid)) & ((u == 1) ? 32'hF : 32'h1));
                @(negedge clk);
                chk("fill_cyc", 32'(cyc[u]), 32'd0);
                tick();
            end
            s_en[u] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            s_ack[u] = (c == ncyc);
            @(negedge clk);
            chk("req_cyc", 32'(cyc[u]), 32'd1);
            chk("req_done", 32'(done[u]), 32'd0);
            tick();
        end
        s_ack[u] = 1'b0;
        if (!m_we) begin
            for (int c = 0; c < n; c++) begin
                if (poke && c == 2) begin
                    s_start[u] = 1'b1; s_we[u] = 1'b1; s_f3[u] = 3'b010; s_adr[u] = 32'hDEAD_0000;
                end else begin
                    s_start[u] = 1'b0;
                end
                @(negedge clk);
                chk("drain_valid", 32'(rvalid[u]), 32'd1);
                chk("drain_cyc", 32'(cyc[u]), 32'd0);
                chk("drain_done", 32'(done[u]), 32'd0);
                tick();
            end
            s_start[u] = 1'b0;
            chk("drain_count", 32'(m_idx), 32'(n));
        end
        if (chain) op_set(u, n_we, n_f3, n_adr, n_lsb, n_wdat, n_rdt);
        @(negedge clk);
        chk("done_pulse", 32'(done[u]), 32'd1);
        chk("done_idle", 32'(busy[u]), 32'd0);
        chk("done_valid", 32'(rvalid[u]), 32'd0);
        chk("done_cyc", 32'(cyc[u]), 32'd0);
        if (!chain) begin
            tick();
            @(negedge clk);
            chk("done_once", 32'(done[u]), 32'd0);
        end
    endtask

    // Compare process: bus fields and serial load chunks against the model every cycle.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rvalid[u]) begin
                chk("rd_zero", 32'(rd[u]), 32'd0);
            end else if (u == m_u && !m_we && m_idx < ((u == 1) ? 8 : 32)) begin
                chk("rd_chunk", 32'(rd[u]),
                    (m_res >> (m_idx * ((u == 1) ? 4 : 1))) & ((u == 1) ? 32'hF : 32'h1));
                m_idx++;
            end else begin
                chk("rd_unexpected", 32'(rvalid[u]), 32'd0);
            end
            if (cyc[u] && u == m_u) begin
                chk("bus_adr", d_adr[u], m_adr);
                chk("bus_sel", 32'(d_sel[u]), 32'(m_sel));
                chk("bus_we", 32'(d_we[u]), 32'(m_we));
                if (m_we) chk("bus_dat", d_dat[u], m_dat);
            end
            if (!cyc[u]) chk("we_idle", 32'(d_we[u]), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          l;
        for (int u = 0; u < 2; u++) begin
            s_rst[u] = 1'b1; s_start[u] = 1'b0; s_we[u] = 1'b0; s_f3[u] = 3'd0;
            s_adr[u] = 32'd0; s_lsb[u] = 2'd0; s_en[u] = 1'b0; s_rs2[u] = 4'd0;
            s_rdt[u] = 32'd0; s_ack[u] = 1'b0;
        end
        tick(); tick();
        s_rst[0] = 1'b0; s_rst[1] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", 32'(busy[u]), 32'd0);
            chk("rst_cyc", 32'(cyc[u]), 32'd0);
            chk("rst_valid", 32'(rvalid[u]), 32'd0);
            chk("rst_done", 32'(done[u]), 32'd0);
            chk("rst_we", 32'(d_we[u]), 32'd0);
            chk("rst_rd", 32'(rd[u]), 32'd0);
        end

        // W=1 load word, ack in the third cyc cycle
        op_set(0, 1'b0, 3'b010, 32'h0000_0100, 0, 32'd0, 32'h8765_4321);
        chk("pin_lw", m_res, 32'h8765_4321);
        chk("pin_lw_sel", 32'(m_sel), 32'hF);
        op_run(3, 0, 1'b0, 1'b0);

        // W=4 lb / lbu at lsb=3
        op_set(1, 1'b0, 3'b000, 32'h0000_2000, 3, 32'd0, 32'h80AB_CDEF);
        chk("pin_lb", m_res, 32'hFFFF_FF80);
        chk("pin_lb_sel", 32'(m_sel), 32'h8);
        op_run(2, 0, 1'b0, 1'b0);
        op_set(1, 1'b0, 3'b100, 32'h0000_2000, 3, 32'd0, 32'h80AB_CDEF);
        chk("pin_lbu", m_res, 32'h0000_0080);
        op_run(1, 0, 1'b0, 1'b0);

        // W=4 sh at lsb=2, i_en toggling
        op_set(1, 1'b1, 3'b001, 32'h0000_3000, 2, 32'h0000_BEEF, 32'd0);
        chk("pin_sh_dat", m_dat, 32'hBEEF_BEEF);
        chk("pin_sh_sel", 32'(m_sel), 32'hC);
        op_run(2, 1, 1'b0, 1'b0);

        // W=1 sb at lsb=1
        op_set(0, 1'b1, 3'b000, 32'h0000_4000, 1, 32'h1234_5678, 32'd0);
        chk("pin_sb_dat", m_dat, 32'h7878_7878);
        chk("pin_sb_sel", 32'(m_sel), 32'h2);
        op_run(1, 0, 1'b0, 1'b0);

        // Reset mid-REQ, late ack ignored
        op_set(1, 1'b0, 3'b010, 32'h0000_0200, 0, 32'd0, 32'hCAFE_F00D);
        tick();
        s_start[1] = 1'b0;
        @(negedge clk);
        chk("rst_req_cyc", 32'(cyc[1]), 32'd1);
        tick();
        s_rst[1] = 1'b1;
        tick();
        s_rst[1] = 1'b0;
        s_ack[1] = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", 32'(cyc[1]), 32'd0);
        chk("rst_mid_busy", 32'(busy[1]), 32'd0);
        tick();
        s_ack[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late_ack_valid", 32'(rvalid[1]), 32'd0);
            chk("late_ack_done", 32'(done[1]), 32'd0);
            chk("late_ack_busy", 32'(busy[1]), 32'd0);
            tick();
        end
        op_set(1, 1'b0, 3'b001, 32'h0000_0204, 2, 32'd0, 32'h9ABC_1234);
        chk("pin_lh", m_res, 32'hFFFF_9ABC);
        op_run(1, 0, 1'b0, 1'b0);

        // Start poked during DRAIN is ignored; start in the done cycle is taken
        n_we = 1'b0; n_f3 = 3'b101; n_adr = 32'h0000_0300; n_lsb = 0;
        n_wdat = 32'd0; n_rdt = 32'h0000_8001;
        op_set(1, 1'b0, 3'b010, 32'h0000_0208, 0, 32'd0, 32'h0F1E_2D3C);
        op_run(2, 0, 1'b1, 1'b1);
        chk("pin_lhu", m_res, 32'h0000_8001);
        op_run(1, 0, 1'b0, 1'b0);

        // Randomized operations on both units
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 2));
            f[2] = 1'($urandom_range(0, 1));
            l = (f[1:0] == 2'b00) ? int'($urandom_range(0, 3)) :
                (f[1:0] == 2'b01) ? 2 * int'($urandom_range(0, 1)) : 0;
            a = $urandom();
            a[1:0] = 2'b00;
            op_set(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f, a, l,
                   $urandom(), $urandom());
            op_run(int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        // Stray ack while idle
        s_ack[0] = 1'b1; s_ack[1] = 1'b1;
        tick();
        s_ack[0] = 1'b0; s_ack[1] = 1'b0;
        @(negedge clk);
        chk("idle_ack_busy0", 32'(busy[0]), 32'd0);
        chk("idle_ack_done1", 32'(done[1]), 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
